// File: rtl/ram_writer_if.sv
// ram_writer_if: byte-stream input and SB_RAM256x16-style write port of ram_writer.
//   in_data_i/in_valid_i/in_ready_o : valid/ready byte stream (master drives data/valid)
//   waddr_o/wdata_o/wmask_o/we_o    : registered RAM write port (slave drives)
//   wmask_o uses the iCE40 sense: 1 = bit is NOT written.
// Member names keep the block's _i/_o port names as seen from ram_writer.
interface ram_writer_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int WORD_WIDTH = 16
);
    logic [7:0]            in_data_i;
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [ADDR_WIDTH-1:0] waddr_o;
    logic [WORD_WIDTH-1:0] wdata_o;
    logic [WORD_WIDTH-1:0] wmask_o;
    logic                  we_o;

    modport master (
        output in_data_i, in_valid_i,
        input  in_ready_o, waddr_o, wdata_o, wmask_o, we_o
    );

    modport slave (
        input  in_data_i, in_valid_i,
        output in_ready_o, waddr_o, wdata_o, wmask_o, we_o
    );
endinterface

// File: rtl/ram_writer.sv
// ram_writer: packs a host byte stream little-endian into WORD_WIDTH (8 or 16)
// words and issues registered writes to an iCE40 block RAM.
//   clk_i, rstn_i : clock (rising edge), async active-low reset
//   start_i       : pulse, (re)starts a load at address 0
//   flush_i       : pulse, ends the load, committing a pending half word
//   bus (slave)   : byte stream in, RAM write port out (see ram_writer_if)
//   count_o       : words written in the current load (saturates at VECTOR_LENGTH)
//   done_o        : load ended by flush or by filling the memory
module ram_writer #(
    parameter int VECTOR_LENGTH = 512,
    parameter int WORD_WIDTH    = 16,
    parameter int ADDR_WIDTH    = $clog2(VECTOR_LENGTH)
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                start_i,
    input  logic                flush_i,
    ram_writer_if.slave         bus,
    output logic [ADDR_WIDTH:0] count_o,
    output logic                done_o
);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(VECTOR_LENGTH - 1);
    localparam logic [ADDR_WIDTH:0]   FULL_CNT  = (ADDR_WIDTH + 1)'(VECTOR_LENGTH);

    state_t                r_state, w_state;
    logic                  r_ready, w_ready;
    logic                  r_we, w_we;
    logic                  r_done, w_done;
    logic [ADDR_WIDTH-1:0] r_waddr, w_waddr;
    logic [WORD_WIDTH-1:0] r_wdata, w_wdata;
    logic [WORD_WIDTH-1:0] r_wmask, w_wmask;
    logic [ADDR_WIDTH:0]   r_count, w_count;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr;     // next address to be written
    logic                  r_half, w_half;     // low byte of a 16-bit word is held
    logic [7:0]            r_lo, w_lo;

    logic                  w_acc;
    logic                  w_wr;
    logic [15:0]           w_word16;
    logic [15:0]           w_mask16;

    assign w_acc = bus.in_valid_i && r_ready;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_wmask <= '1;
            r_count <= '0;
            r_addr  <= '0;
            r_half  <= 1'b0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state;
            r_ready <= w_ready;
            r_we    <= w_we;
            r_done  <= w_done;
            r_waddr <= w_waddr;
            r_wdata <= w_wdata;
            r_wmask <= w_wmask;
            r_count <= w_count;
            r_addr  <= w_addr;
            r_half  <= w_half;
            r_lo    <= w_lo;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_ready  = r_ready;
        w_we     = 1'b0;
        w_done   = r_done;
        w_waddr  = r_waddr;
        w_wdata  = r_wdata;
        w_wmask  = r_wmask;
        w_count  = r_count;
        w_addr   = r_addr;
        w_half   = r_half;
        w_lo     = r_lo;
        w_wr     = 1'b0;
        w_word16 = '0;
        w_mask16 = '0;

        if (start_i) begin
            // Start wins over everything, including a byte or flush in the same cycle.
            w_state = FILL;
            w_ready = 1'b1;
            w_done  = 1'b0;
            w_count = '0;
            w_addr  = '0;
            w_half  = 1'b0;
        end else if (r_state == FILL) begin
            if (w_acc) begin
                if (WORD_WIDTH == 8) begin
                    w_wr     = 1'b1;
                    w_word16 = {8'h00, bus.in_data_i};
                end else if (r_half) begin
                    w_wr     = 1'b1;
                    w_word16 = {bus.in_data_i, r_lo};
                    w_half   = 1'b0;
                end else begin
                    w_half = 1'b1;
                    w_lo   = bus.in_data_i;
                end
            end

            // Flush sees the half flag after this cycle's byte, so a byte that
            // completes a word suppresses the partial write.
            if (flush_i) begin
                w_state = DONE;
                w_ready = 1'b0;
                w_done  = 1'b1;
                if (w_half) begin
                    w_wr     = 1'b1;
                    w_word16 = {8'h00, w_lo};
                    w_mask16 = 16'hFF00;
                    w_half   = 1'b0;
                end
            end

            if (w_wr) begin
                w_we    = 1'b1;
                w_waddr = r_addr;
                w_wdata = w_word16[WORD_WIDTH-1:0];
                w_wmask = w_mask16[WORD_WIDTH-1:0];
                if (r_count != FULL_CNT)
                    w_count = r_count + 1'b1;
                // Last word: stop in the same edge so no byte is taken beyond capacity.
                if (r_addr == LAST_ADDR) begin
                    w_state = DONE;
                    w_ready = 1'b0;
                    w_done  = 1'b1;
                end else begin
                    w_addr = r_addr + 1'b1;
                end
            end
        end else if (r_state != IDLE && r_state != DONE) begin
            w_state = IDLE;
            w_ready = 1'b0;
        end
    end

    assign bus.in_ready_o = r_ready;
    assign bus.waddr_o    = r_waddr;
    assign bus.wdata_o    = r_wdata;
    assign bus.wmask_o    = r_wmask;
    assign bus.we_o       = r_we;
    assign count_o        = r_count;
    assign done_o         = r_done;

endmodule

// File: doc/ram_writer.md
Name: ram_writer

Overview:
- Write-side companion to the team's iCE40 ROM/RAM read blocks.
- Accepts a byte stream from the USB CDC OUT data path using a valid/ready handshake.
- Packs the bytes little-endian into WORD_WIDTH words and drives a registered write port matching the SB_RAM256x16 write side: address, data, active-high bit mask, write enable.
- Used to load RAM contents from the host so the existing read-side logic can read them back.

Parameters:
- VECTOR_LENGTH, 'd512, depth of the target memory in WORD_WIDTH words.
- WORD_WIDTH, 'd16, width of the memory word; legal values are 8 or 16.
- ADDR_WIDTH, ceil_log2(VECTOR_LENGTH), width of the word address.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rstn_i  input  1  asynchronous, active-low reset.
- start_i  input  1  single-cycle pulse; clears address and count and begins a load.
- flush_i  input  1  single-cycle pulse; ends the load and commits any pending partial word.
- in_data_i  input  8  stream byte.
- in_valid_i  input  1  in_data_i is valid.
- in_ready_o  output  1  block can accept a byte; transfer occurs when in_valid_i && in_ready_o.
- waddr_o  output  ADDR_WIDTH  write address.
- wdata_o  output  WORD_WIDTH  write data.
- wmask_o  output  WORD_WIDTH  per-bit mask; 1 = bit not written (iCE40 convention).
- we_o  output  1  write enable; one-cycle pulse per word.
- count_o  output  ADDR_WIDTH+1  number of words written in the current load.
- done_o  output  1  load finished, either by flush or because memory is full.

Behaviour:
- Reset (async assert, sync deassert):
  - state = IDLE; in_ready_o = 0; we_o = 0; done_o = 0.
  - waddr_o, wdata_o, count_o = 0; wmask_o = all ones; half-word flag = 0.
- States: IDLE, FILL, DONE. All outputs are registered.
- IDLE: in_ready_o = 0. start_i -> FILL with waddr = 0, count = 0, half flag = 0.
- FILL: in_ready_o = 1. Handling of an accepted byte:
  - WORD_WIDTH 8: the next cycle gives we_o = 1, wdata_o = byte, wmask_o = 0, waddr_o = current address. The address then increments.
  - WORD_WIDTH 16, half flag = 0: the byte goes to the low holding register [7:0]; half flag is set; no write.
  - WORD_WIDTH 16, half flag = 1: the next cycle gives we_o = 1, wdata_o = {byte, held low byte}, wmask_o = 0. Half flag clears and the address increments.
- Write timing:
  - Latency is exactly 1 cycle from the completing handshake to the we_o pulse.
  - count_o increments in the same cycle as we_o.
  - A back-to-back stream sustains 1 byte/cycle.
- Full:
  - When the write to address VECTOR_LENGTH-1 is issued, go to DONE in that cycle.
  - in_ready_o drops in the cycle after the completing handshake. No byte is accepted beyond memory capacity.
  - The address never wraps.
- flush_i in FILL:
  - Half flag = 1 (16-bit mode only): issue a partial write next cycle with wdata_o = {8'h00, held byte} and wmask_o = 16'hFF00. count_o increments. Go to DONE.
  - Half flag = 0: go to DONE with no write.
  - in_ready_o = 0 from the cycle after flush_i.
- flush_i together with an accepted byte: the byte is taken first, then the flush is applied. Consequences in 16-bit mode:
  - Byte completes a word: one full write, no partial write.
  - Byte is a new low byte: one partial write containing it.
- DONE: done_o = 1 and in_ready_o = 0. Hold until start_i, which behaves as in IDLE and clears done_o.
- start_i in FILL restarts the load:
  - The pending half byte is discarded.
  - A byte accepted in the same cycle is discarded.
  - waddr and count return to 0.
- we_o is 0 in every cycle not listed above. wdata_o, waddr_o and wmask_o hold their last values when we_o = 0.
- Reset mid-load: aborts immediately to IDLE; a pending write is dropped.
- in_valid_i is ignored whenever in_ready_o = 0.
- Width rules:
  - count_o saturates at VECTOR_LENGTH.
  - In 8-bit mode the half flag is never set and flush never produces a partial write.

Test Plan:
- WORD_WIDTH 16: start, stream bytes 0x11,0x22,0x33,0x44 back-to-back -> writes addr 0 = 0x2211, addr 1 = 0x4433, each 1 cycle after its second byte; count_o = 2.
- WORD_WIDTH 16: start, bytes 0xAB,0xCD,0xEF, then flush -> addr 0 = 0xCDAB with mask 0x0000; addr 1 = 0x00EF with mask 0xFF00; count_o = 2; done_o = 1.
- WORD_WIDTH 8, VECTOR_LENGTH 4: stream 6 bytes with in_valid_i held high -> exactly 4 writes at addr 0..3; in_ready_o low after the 4th handshake; done_o = 1; bytes 5-6 never accepted.
- WORD_WIDTH 16: byte 0x55 accepted in the same cycle as flush_i -> one partial write 0x0055, mask 0xFF00; no further writes.
- WORD_WIDTH 16: bytes 0x01 then start_i, then 0x02,0x03 -> single write addr 0 = 0x0302; 0x01 discarded; count_o = 1.
- Assert rstn_i low between the two bytes of a word -> no we_o pulse; outputs return to reset values immediately; in_ready_o = 0 until the next start_i.
